// File: rtl/visualizer_ctrl.sv
// Source/half selector for a 32-bit LED visualizer: debounced buttons, refresh
// prescaler, and a manual/auto-scroll FSM choosing which half is shown.
module visualizer_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REFRESH_DIV     = 1000,
  parameter int SCROLL_TICKS    = 500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  input  logic        btn_next,
  input  logic        btn_half,
  input  logic        auto_en,
  input  logic        freeze,
  output logic [31:0] data_bits,
  output logic        toggle_btn,
  output logic [1:0]  src_sel,
  output logic        refresh_tick
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PS_W = $clog2(REFRESH_DIV + 1);
  localparam int SC_W = $clog2(SCROLL_TICKS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(REFRESH_DIV - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_TICKS - 1);

  typedef enum logic [1:0] {MANUAL, AUTO_LO, AUTO_HI} state_t;

  // bit 0 = btn_next, bit 1 = btn_half throughout the button path
  logic [1:0]      sync_p0, sync_p1;
  logic [1:0]      level, level_d;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;
  logic            next_p, half_p;

  logic [PS_W-1:0] presc;
  logic [SC_W-1:0] scroll, scroll_n;
  state_t          state, state_n;
  logic            toggle_n;
  logic [1:0]      sel_n;

  // Stage p0/p1: two-flop synchronizer, then per-button debounce
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= {btn_half, btn_next};
      sync_p1 <= sync_p0;
      level_d <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press  = level & ~level_d;
  assign next_p = press[0];
  assign half_p = press[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) presc <= '0;
    else     presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
  end

  assign refresh_tick = (presc == PS_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= MANUAL;
      scroll     <= '0;
      toggle_btn <= 1'b1;
      src_sel    <= '0;
    end else begin
      state      <= state_n;
      scroll     <= scroll_n;
      toggle_btn <= toggle_n;
      src_sel    <= sel_n;
    end
  end

  // next_p is applied first; state-specific branches only override it where
  // they must, so half_p is naturally discarded when both coincide.
  always_comb begin
    state_n  = state;
    scroll_n = scroll;
    toggle_n = toggle_btn;
    sel_n    = src_sel;
    if (next_p) begin
      sel_n    = src_sel + 2'd1;
      toggle_n = 1'b1;
      scroll_n = '0;
    end
    case (state)
      MANUAL: begin
        if (auto_en) begin
          state_n  = AUTO_LO;
          toggle_n = 1'b1;
          scroll_n = '0;
        end else if (half_p && !next_p) begin
          toggle_n = ~toggle_btn;
        end
      end
      AUTO_LO, AUTO_HI: begin
        if (!auto_en) begin
          state_n = MANUAL;
        end else if (next_p) begin
          state_n = AUTO_LO;
        end else if (refresh_tick) begin
          if (scroll == SC_LAST) begin
            scroll_n = '0;
            state_n  = (state == AUTO_LO) ? AUTO_HI : AUTO_LO;
            toggle_n = (state == AUTO_HI);
          end else begin
            scroll_n = scroll + SC_W'(1);
          end
        end
      end
      default: state_n = MANUAL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_bits <= '0;
    end else if (!freeze) begin
      case (src_sel)
        2'd0:    data_bits <= src0;
        2'd1:    data_bits <= src1;
        2'd2:    data_bits <= src2;
        default: data_bits <= src3;
      endcase
    end
  end

endmodule

// File: doc/visualizer_ctrl.md
VISUALIZER_CTRL -- requirements
Module: visualizer_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have parameter REFRESH_DIV, default 1000: CLK cycles per refresh_tick.
REQ-003 SHALL have parameter SCROLL_TICKS, default 500: refresh_ticks per half in auto-scroll.
REQ-004 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-005 CLK  input  1  sole clock, all state on rising edge.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 src0, src1, src2, src3  input  32 each  candidate words to display.
REQ-008 btn_next  input  1  raw, asynchronous button: advance source.
REQ-009 btn_half  input  1  raw, asynchronous button: swap displayed half.
REQ-010 auto_en  input  1  synchronous level: 1 = auto-scroll halves.
REQ-011 freeze  input  1  synchronous level: 1 = hold data_bits.
REQ-012 data_bits  output  32  registered selected word, drives the 32-bit visualizer.
REQ-013 toggle_btn  output  1  registered half select: 1 = low half [15:0] ("L"), 0 = high half [31:16] ("H").
REQ-014 src_sel  output  2  registered index of the current source.
REQ-015 refresh_tick  output  1  one-cycle pulse, display-refresh enable.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer, then a debounce counter: the accepted level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce clears the counter.
REQ-017 A rising edge of an accepted level SHALL produce exactly one 1-cycle internal press pulse (next_p, half_p); a held button produces no repeats.
REQ-018 refresh_tick: a prescaler SHALL count 0..REFRESH_DIV-1 and wrap; refresh_tick = 1 only in the cycle the count equals REFRESH_DIV-1.
REQ-019 next_p SHALL increment src_sel modulo 4 (3 wraps to 0), set toggle_btn = 1, and clear the scroll counter.
REQ-020 data_bits SHALL be loaded with src[src_sel] every cycle while freeze = 0 (1-cycle latency from a src or src_sel change); while freeze = 1, data_bits SHALL hold, while src_sel and toggle_btn still update.
REQ-021 FSM states: MANUAL, AUTO_LO (toggle_btn = 1), AUTO_HI (toggle_btn = 0).
REQ-022 MANUAL: half_p inverts toggle_btn; auto_en = 1 -> AUTO_LO next cycle, toggle_btn = 1, scroll counter = 0.
REQ-023 AUTO_LO/AUTO_HI: the scroll counter SHALL increment on refresh_tick; on the tick that makes it reach SCROLL_TICKS, it clears and the FSM swaps AUTO_LO <-> AUTO_HI.
REQ-024 In AUTO states half_p SHALL be ignored; next_p SHALL force AUTO_LO.
REQ-025 In any AUTO state, auto_en = 0 SHALL return to MANUAL next cycle, toggle_btn keeping its current value.
REQ-026 next_p and half_p in the same cycle: next_p SHALL take effect and half_p SHALL be discarded.
REQ-027 next_p coinciding with a scroll swap SHALL result in AUTO_LO with the scroll counter = 0.

Reset
REQ-028 While RST = 1: data_bits = 0, src_sel = 0, toggle_btn = 1, refresh_tick = 0, FSM = MANUAL, and the prescaler, scroll counter, debounce counters, synchronizers and accepted levels = 0.
REQ-029 Reset asserted mid-debounce or mid-scroll SHALL discard all progress; after RST falls, operation restarts from the REQ-028 values with no spurious press pulse.

Verification (DEBOUNCE_CYCLES=4, REFRESH_DIV=4, SCROLL_TICKS=2)
REQ-030 Reset, src0=0xDEADBEEF, idle -> data_bits=0xDEADBEEF one cycle after RST falls; toggle_btn=1; refresh_tick pulses every 4th cycle.
REQ-031 btn_next held 10 cycles, with 1-cycle glitches before the hold -> exactly one increment, src_sel 0->1, data_bits=src1; four presses from src_sel=3 end at src_sel=3 via wrap 3->0.
REQ-032 MANUAL, btn_half pressed twice -> toggle_btn 1->0->1; both buttons pressed simultaneously -> src_sel +1, toggle_btn=1.
REQ-033 auto_en=1 -> AUTO_LO, toggle_btn flips every 8 cycles (2 ticks); btn_half is ignored; auto_en=0 while in AUTO_HI -> MANUAL with toggle_btn=0.
REQ-034 freeze=1, then src0 changes 0x1 -> 0x2 -> data_bits stays 0x1; freeze=0 -> 0x2 one cycle later.
REQ-035 RST pulsed during AUTO_HI, src_sel=2 -> all outputs return to REQ-028 values immediately, with no press pulse after release.
